// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame defaults, FSM state encoding and helpers for the transmitter and receiver
// Contents: NB_DATA_DEF, OVERSAMPLE_DEF, SB_TICK_DEF, uart_state_t (one-hot), max2()
package uart_pkg;
  localparam int NB_DATA_DEF    = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_START = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_STOP  = 4'b1000
  } uart_state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: transmit request/status bundle between a byte producer (master) and uart_tx (slave)
// Signals: i_tx_start (send request), i_data (byte), o_tx (serial line), o_tx_done (end-of-frame pulse), o_busy
interface uart_tx_if import uart_pkg::*; #(
  parameter int NB_DATA = NB_DATA_DEF
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_tx_done;
  logic               o_busy;
  modport master (output i_tx_start, i_data, input o_tx, o_tx_done, o_busy);
  modport slave  (input i_tx_start, i_data, output o_tx, o_tx_done, o_busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter, 1 start bit, NB_DATA data bits LSB first, SB_TICK/OVERSAMPLE stop bits
// Ports: i_clock (rising edge), i_reset (sync, active-low), i_tick (baud x OVERSAMPLE strobe),
//        tx_if (slave: i_tx_start, i_data in; o_tx, o_tx_done, o_busy out)
module uart_tx import uart_pkg::*; #(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int SB_TICK    = SB_TICK_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_tick,
  uart_tx_if.slave tx_if
);
  localparam int TW = $clog2(max2(OVERSAMPLE, SB_TICK));
  localparam int BW = $clog2(NB_DATA + 1);
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

  uart_state_t        r_state, w_state;
  logic [TW-1:0]      r_tick_cnt, w_tick_cnt;
  logic [BW-1:0]      r_bit_cnt, w_bit_cnt;
  logic [NB_DATA-1:0] r_shreg, w_shreg;
  logic               r_tx, w_tx;
  logic               r_done, w_done;
  logic               r_busy, w_busy;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick_cnt <= w_tick_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shreg    <= w_shreg;
      r_tx       <= w_tx;
      r_done     <= w_done;
      r_busy     <= w_busy;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_tick_cnt = r_tick_cnt;
    w_bit_cnt  = r_bit_cnt;
    w_shreg    = r_shreg;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE:
        if (tx_if.i_tx_start) begin
          w_state    = ST_START;
          w_tick_cnt = '0;
          w_shreg    = tx_if.i_data;
        end
      ST_START:
        if (i_tick) begin
          if (r_tick_cnt == OS_LAST) begin
            w_state    = ST_DATA;
            w_tick_cnt = '0;
            w_bit_cnt  = '0;
          end else w_tick_cnt = r_tick_cnt + 1'b1;
        end
      ST_DATA:
        if (i_tick) begin
          if (r_tick_cnt == OS_LAST) begin
            w_tick_cnt = '0;
            w_shreg    = r_shreg >> 1;
            w_bit_cnt  = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) w_state = ST_STOP;
          end else w_tick_cnt = r_tick_cnt + 1'b1;
        end
      ST_STOP:
        if (i_tick) begin
          if (r_tick_cnt == SB_LAST) begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
          end else w_tick_cnt = r_tick_cnt + 1'b1;
        end
      default: w_state = ST_IDLE;
    endcase
    // The line level is computed from the next state so o_tx comes straight from a flop
    // and changes on the same edge as the state it represents.
    w_tx   = (w_state == ST_START) ? 1'b0 : (w_state == ST_DATA) ? w_shreg[0] : 1'b1;
    w_busy = (w_state != ST_IDLE);
  end

  assign tx_if.o_tx      = r_tx;
  assign tx_if.o_tx_done = r_done;
  assign tx_if.o_busy    = r_busy;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx; a tick-count frame model predicts o_tx/o_busy/o_tx_done every clock
module tb_uart_tx;
  localparam int OS = 16;
  localparam int NB = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rd;

  uart_tx_if #(.NB_DATA(NB)) if_a ();
  uart_tx_if #(.NB_DATA(NB)) if_b ();

  uart_tx #(.NB_DATA(NB), .SB_TICK(16), .OVERSAMPLE(OS)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .tx_if(if_a)
  );
  uart_tx #(.NB_DATA(NB), .SB_TICK(32), .OVERSAMPLE(OS)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .tx_if(if_b)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      tick = (ph == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [7:0] d);
    if (sel) begin
      if_b.i_tx_start = st;
      if_b.i_data = d;
    end else begin
      if_a.i_tx_start = st;
      if_a.i_data = d;
    end
  endtask

  task automatic chk_out(input bit sel, input string tag, input logic e_tx, input logic e_busy, input logic e_done);
    chk({tag, "_tx"}, sel ? if_b.o_tx : if_a.o_tx, e_tx);
    chk({tag, "_busy"}, sel ? if_b.o_busy : if_a.o_busy, e_busy);
    chk({tag, "_done"}, sel ? if_b.o_tx_done : if_a.o_tx_done, e_done);
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      chk_out(sel, "idle", 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Model: after acceptance, the line is a pure function of ticks seen t:
  // start for OS ticks, data bit k for the next OS ticks each, then high for sb ticks, done when t hits total.
  task automatic frame(input bit sel, input logic [7:0] d, input int spoil_t, input int abort_t);
    int sb, total, t, stop_clks;
    bit spoiled;
    logic e_tx;
    sb = sel ? 32 : 16;
    total = OS * (NB + 1) + sb;
    t = 0;
    stop_clks = 0;
    spoiled = 0;
    drive(sel, 1'b1, d);
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      drive(sel, 1'b0, 8'($urandom));
      if (t >= OS * (NB + 1) && t < total) stop_clks++;
      e_tx = t < OS ? 1'b0 : t < OS * (NB + 1) ? d[t / OS - 1] : 1'b1;
      chk_out(sel, "frame", e_tx, t < total, t == total);
      if (t == total) begin
        chk("stop_len", stop_clks, 4 * sb);
        return;
      end
      if (t == spoil_t && !spoiled) begin
        spoiled = 1;
        drive(sel, 1'b1, 8'hFF);
      end
      if (t == abort_t) begin
        rst_n = 1'b0;
        drive(sel, 1'b1, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        drive(sel, 1'b0, 8'h00);
        chk_out(sel, "abort", 1'b1, 1'b0, 1'b0);
        idle(sel, 700);
        return;
      end
      @(posedge clk);
      if (tick) t++;
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_out(0, "reset_a", 1'b1, 1'b0, 1'b0);
    chk_out(1, "reset_b", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(0, 3);
    frame(0, 8'hA5, -1, -1);
    frame(0, 8'h3C, -1, -1);
    idle(0, 20);
    frame(0, 8'h00, OS * 3 + 5, -1);
    idle(0, 700);
    frame(0, 8'h55, -1, OS * 4 + 8);
    frame(0, 8'h81, -1, -1);
    idle(0, 10);
    frame(1, 8'h0F, -1, -1);
    idle(1, 10);
    repeat (6) begin
      rd = 8'($urandom);
      frame(0, rd, -1, -1);
      idle(0, $urandom_range(0, 7));
    end
    repeat (2) begin
      rd = 8'($urandom);
      frame(1, rd, -1, -1);
      idle(1, $urandom_range(0, 7));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
